op_router_node: RTL and testbench

//  Registered, parametrised successor of the node-0 op decoder: takes op words (ID[11:8], OPF[7:4])
//  on a valid/ready input and routes each to one of N_TASK task channels or N_PERIPH peripheral channels.

---
 rtl/op_router_node.sv | 101 ++++++++++
 tb/tb_op_router_node.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/op_router_node.sv
// op_router_node: registered op router to task/peripheral/ESPIC channels; `OP_ROUTER_STATS_EN adds drop/ESPIC counters
module op_router_node #(
    parameter int W = 16,
    parameter int ID_LSB = 8,
    parameter int OPF_LSB = 4,
    parameter int N_TASK = 6,
    parameter int N_PERIPH = 3,
    parameter int PERIPH_BASE = 10,
    parameter logic [3:0] ESPIC_CODE = 4'hF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          in_op,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [N_TASK*W-1:0]   task_op,
    output logic [N_TASK-1:0]     task_valid,
    input  logic [N_TASK-1:0]     task_ready,
    output logic [N_PERIPH*W-1:0] periph_op,
    output logic [N_PERIPH-1:0]   periph_valid,
    input  logic [N_PERIPH-1:0]   periph_ready,
    output logic [W-1:0]          espic_op,
    output logic                  espic_valid,
    input  logic                  espic_ready,
    output logic                  drop_pulse
`ifdef OP_ROUTER_STATS_EN
    ,
    output logic [15:0]           drop_cnt,
    output logic [15:0]           espic_cnt
`endif
);
    logic [3:0] id, opf;
    logic esp, esp_only, need_esp, routable, prim_free, espic_free, accept;
    logic [N_TASK-1:0] task_hit, task_free;
    logic [N_PERIPH-1:0] periph_hit, periph_free;
    logic [N_TASK-1:0][W-1:0] task_q;
    logic [N_PERIPH-1:0][W-1:0] periph_q;

    assign task_op = task_q;
    assign periph_op = periph_q;
    assign task_free = ~task_valid | task_ready;
    assign periph_free = ~periph_valid | periph_ready;
    assign espic_free = ~espic_valid | espic_ready;

    // decode the op at the input and decide whether every destination it needs has room
    always_comb begin
        id = in_op[ID_LSB+:4];
        opf = in_op[OPF_LSB+:4];
        esp = opf == ESPIC_CODE;
        for (int k = 0; k < N_TASK; k++) task_hit[k] = {1'b0, id} == 5'(k + 1);
        for (int k = 0; k < N_PERIPH; k++) periph_hit[k] = {1'b0, id} == 5'(PERIPH_BASE + k);
        esp_only = esp & (id == 4'd0);
        need_esp = esp_only | (esp & |task_hit);
        routable = |task_hit | |periph_hit | esp_only;
        prim_free = |(task_hit & task_free) | |(periph_hit & periph_free) | esp_only;
        in_ready = ~routable | (prim_free & (~need_esp | espic_free));
        accept = in_valid & in_ready;
    end

    // one-entry output registers: load on accept, otherwise drain on ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            task_valid <= '0;
            task_q <= '0;
            periph_valid <= '0;
            periph_q <= '0;
            espic_valid <= 1'b0;
            espic_op <= '0;
            drop_pulse <= 1'b0;
        end else begin
            for (int k = 0; k < N_TASK; k++)
                if (accept & task_hit[k]) begin
                    task_valid[k] <= 1'b1;
                    task_q[k] <= in_op;
                end else if (task_ready[k]) task_valid[k] <= 1'b0;
            for (int k = 0; k < N_PERIPH; k++)
                if (accept & periph_hit[k]) begin
                    periph_valid[k] <= 1'b1;
                    periph_q[k] <= in_op;
                end else if (periph_ready[k]) periph_valid[k] <= 1'b0;
            if (accept & need_esp) begin
                espic_valid <= 1'b1;
                espic_op <= in_op;
            end else if (espic_ready) espic_valid <= 1'b0;
            drop_pulse <= accept & ~routable;
        end
    end

`ifdef OP_ROUTER_STATS_EN
    // saturating event counters for dropped ops and ESPIC loads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
            espic_cnt <= '0;
        end else begin
            if (accept & ~routable & (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
            if (accept & need_esp & (espic_cnt != 16'hFFFF)) espic_cnt <= espic_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_op_router_node.sv
// tb_op_router_node: directed + random checks of op_router_node against a slot-level reference model
module tb_op_router_node;
    logic clk = 1'b0, rst = 1'b1;
    logic [15:0] in_op = '0;
    logic in_valid = 1'b0, in_ready;
    logic [95:0] task_op;
    logic [5:0] task_valid, task_ready = '1;
    logic [47:0] periph_op;
    logic [2:0] periph_valid, periph_ready = '1;
    logic [15:0] espic_op;
    logic espic_valid, espic_ready = 1'b1, drop_pulse;
`ifdef OP_ROUTER_STATS_EN
    logic [15:0] drop_cnt, espic_cnt;
`endif
    int checks = 0, errors = 0;
    bit mv_t[6], mv_p[3], mv_e, m_drop;
    logic [15:0] mo_t[6], mo_p[3], mo_e;
    int cnt_drop = 0, cnt_esp = 0;

    op_router_node dut (
        .clk(clk), .rst(rst), .in_op(in_op), .in_valid(in_valid), .in_ready(in_ready),
        .task_op(task_op), .task_valid(task_valid), .task_ready(task_ready),
        .periph_op(periph_op), .periph_valid(periph_valid), .periph_ready(periph_ready),
        .espic_op(espic_op), .espic_valid(espic_valid), .espic_ready(espic_ready),
        .drop_pulse(drop_pulse)
`ifdef OP_ROUTER_STATS_EN
        , .drop_cnt(drop_cnt), .espic_cnt(espic_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 6; k++) mv_t[k] = 0;
        for (int k = 0; k < 3; k++) mv_p[k] = 0;
        mv_e = 0;
        m_drop = 0;
        cnt_drop = 0;
        cnt_esp = 0;
    endtask

    function automatic bit m_ready(input logic [15:0] op, input logic [5:0] tr, input logic [2:0] pr, input logic er);
        int id = int'(op[11:8]);
        bit esp = op[7:4] == 4'hF;
        bit ef = !mv_e || er;
        if (id >= 1 && id <= 6) return (!mv_t[id-1] || tr[id-1]) && (!esp || ef);
        if (id >= 10 && id <= 12) return !mv_p[id-10] || pr[id-10];
        if (id == 0 && esp) return ef;
        return 1;
    endfunction

    task automatic check_outputs();
        logic [5:0] etv;
        logic [2:0] epv;
        logic [95:0] eto, oto;
        logic [47:0] epo, opo;
        for (int k = 0; k < 6; k++) begin
            etv[k] = mv_t[k];
            eto[k*16+:16] = mv_t[k] ? mo_t[k] : 16'h0;
            oto[k*16+:16] = mv_t[k] ? task_op[k*16+:16] : 16'h0;
        end
        for (int k = 0; k < 3; k++) begin
            epv[k] = mv_p[k];
            epo[k*16+:16] = mv_p[k] ? mo_p[k] : 16'h0;
            opo[k*16+:16] = mv_p[k] ? periph_op[k*16+:16] : 16'h0;
        end
        chk("task_valid", task_valid, etv);
        chk("task_op", oto, eto);
        chk("periph_valid", periph_valid, epv);
        chk("periph_op", opo, epo);
        chk("espic_valid", espic_valid, mv_e);
        chk("espic_op", mv_e ? espic_op : 16'h0, mv_e ? mo_e : 16'h0);
        chk("drop_pulse", drop_pulse, m_drop);
`ifdef OP_ROUTER_STATS_EN
        chk("drop_cnt", drop_cnt, cnt_drop);
        chk("espic_cnt", espic_cnt, cnt_esp);
`endif
    endtask

    task automatic cyc(input logic [15:0] op, input logic v, input logic [5:0] tr, input logic [2:0] pr, input logic er);
        bit rdy, acc, esp;
        int id;
        in_op = op;
        in_valid = v;
        task_ready = tr;
        periph_ready = pr;
        espic_ready = er;
        #1;
        rdy = m_ready(op, tr, pr, er);
        chk("in_ready", in_ready, rdy);
        acc = v && rdy;
        id = int'(op[11:8]);
        esp = op[7:4] == 4'hF;
        for (int k = 0; k < 6; k++) if (tr[k]) mv_t[k] = 0;
        for (int k = 0; k < 3; k++) if (pr[k]) mv_p[k] = 0;
        if (er) mv_e = 0;
        m_drop = 0;
        if (acc) begin
            if (id >= 1 && id <= 6) begin
                mv_t[id-1] = 1;
                mo_t[id-1] = op;
            end else if (id >= 10 && id <= 12) begin
                mv_p[id-10] = 1;
                mo_p[id-10] = op;
            end else if (!(id == 0 && esp)) begin
                m_drop = 1;
                if (cnt_drop < 65535) cnt_drop++;
            end
            if (esp && id <= 6) begin
                mv_e = 1;
                mo_e = op;
                if (cnt_esp < 65535) cnt_esp++;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        model_reset();
        #12;
        check_outputs();
        chk("rst_task_op", task_op, 96'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // reset mid-stream with task[2] holding an op
        cyc(16'h0300, 1, 6'b111011, 3'b111, 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("rst_task_op_async", task_op, 96'h0);
        chk("rst_periph_op_async", periph_op, 48'h0);
        chk("rst_espic_op_async", espic_op, 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // plain task route, then ESPIC backpressure on a dual write
        cyc(16'h0203, 1, 6'h3F, 3'h7, 1);
        cyc(16'h00F0, 1, 6'h3F, 3'h7, 0);
        cyc(16'h03F1, 1, 6'h3F, 3'h7, 0);
        cyc(16'h03F1, 1, 6'h3F, 3'h7, 1);
        chk("dual_task2", task_op[47:32], 16'h03F1);
        chk("dual_espic", espic_op, 16'h03F1);
        // peripheral routes never copy to ESPIC
        cyc(16'h0B52, 1, 6'h3F, 3'h7, 1);
        cyc(16'h0BF2, 1, 6'h3F, 3'h7, 1);
        // unroutable ids
        cyc(16'h0800, 1, 6'h3F, 3'h7, 1);
        cyc(16'h0010, 1, 6'h3F, 3'h7, 1);
        cyc(16'h0000, 0, 6'h3F, 3'h7, 1);
        // head-of-line blocking behind a full task[0]
        cyc(16'h0100, 1, 6'b111110, 3'h7, 1);
        cyc(16'h0101, 1, 6'b111110, 3'h7, 1);
        cyc(16'h0101, 1, 6'b111110, 3'h7, 1);
        cyc(16'h0101, 1, 6'b111111, 3'h7, 1);
        cyc(16'h0A00, 1, 6'b111111, 3'h7, 1);
        cyc(16'h0000, 0, 6'b111111, 3'h7, 1);
        // randomized traffic with random backpressure
        repeat (400) begin
            logic [15:0] op;
            op = 16'($urandom);
            op[11:8] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) op[7:4] = 4'hF;
            cyc(op, $urandom_range(0, 3) != 0, 6'($urandom), 3'($urandom), $urandom_range(0, 2) != 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
